// File: rtl/mips16_loader_pkg.sv
// Shared types and constants for the MIPS16 program loader.
// Select codes, FSM state encoding and word width.
package mips16_loader_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] SEL_INSTR = 2'b00;
    localparam logic [1:0] SEL_DATA  = 2'b01;
    localparam logic [1:0] SEL_VAL   = 2'b10;
    localparam logic [1:0] SEL_BAD   = 2'b11;

endpackage

// File: rtl/loader_image_reg.sv
// One word-addressed image register with its own write pointer.
// Writes past the last word are dropped and flagged by a pulse.
module loader_image_reg
    import mips16_loader_pkg::*;
#(
    parameter int WORDS = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     we,
    input  logic [WORD_W-1:0]        word,
    output logic [WORDS*WORD_W-1:0]  image,
    output logic                     overflow
);

    localparam int PW = $clog2(WORDS + 1);
    localparam logic [PW-1:0] FULL = PW'(WORDS);

    logic [WORDS*WORD_W-1:0] image_q, image_d;
    logic [PW-1:0]           ptr_q, ptr_d;

    // Place the word at the pointer slot, or flag overflow when full.
    always_comb begin
        image_d  = image_q;
        ptr_d    = ptr_q;
        overflow = 1'b0;
        if (we) begin
            if (ptr_q == FULL) begin
                overflow = 1'b1;
            end else begin
                for (int i = 0; i < WORDS; i++) begin
                    if (ptr_q == PW'(i)) begin
                        image_d[i*WORD_W +: WORD_W] = word;
                    end
                end
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Image and pointer storage; clear behaves like reset.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            image_q <= '0;
            ptr_q   <= '0;
        end else begin
            image_q <= image_d;
            ptr_q   <= ptr_d;
        end
    end

    assign image = image_q;

endmodule

// File: rtl/mips16_program_loader.sv
// Serial loader that assembles instr/data/in_val images for the MIPS16
// core, then runs the core for a bounded number of cycles.
module mips16_program_loader
    import mips16_loader_pkg::*;
#(
    parameter int WORDS      = 24,
    parameter int RUN_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [1:0]               wr_sel,
    input  logic [WORD_W-1:0]        wr_word,
    input  logic                     wr_last,
    input  logic                     clear,
    input  logic                     abort,
    output logic [WORDS*WORD_W-1:0]  in_instr,
    output logic [WORDS*WORD_W-1:0]  in_data,
    output logic [31:0]              in_val,
    output logic                     cpu_rst,
    output logic                     done,
    output logic                     err,
    output logic [15:0]              run_count
);

    localparam logic [15:0] LAST_CNT = 16'(RUN_CYCLES - 1);

    state_e      state_q, state_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic [31:0] val_q, val_d;
    logic [1:0]  vptr_q, vptr_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hs;
    logic        instr_we, data_we;
    logic        instr_ovf, data_ovf;

    assign hs       = wr_valid & wr_ready;
    assign instr_we = hs & (wr_sel == SEL_INSTR);
    assign data_we  = hs & (wr_sel == SEL_DATA);

    loader_image_reg #(.WORDS(WORDS)) u_instr (
        .clk      (clk),
        .rst      (rst),
        .clr      (clear),
        .we       (instr_we),
        .word     (wr_word),
        .image    (in_instr),
        .overflow (instr_ovf)
    );

    loader_image_reg #(.WORDS(WORDS)) u_data (
        .clk      (clk),
        .rst      (rst),
        .clr      (clear),
        .we       (data_we),
        .word     (wr_word),
        .image    (in_data),
        .overflow (data_ovf)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    // Next state; clear overrides abort and normal termination.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: if (hs && wr_last) state_d = RUN;
            RUN:  if (abort || cnt_q == LAST_CNT) state_d = DONE;
            DONE: state_d = DONE;
            default: state_d = LOAD;
        endcase
        if (clear) state_d = LOAD;
    end

    // Decoded outputs; core reset tracks the upcoming state.
    always_comb begin
        wr_ready  = (state_q == LOAD);
        done      = (state_q == DONE);
        cpu_rst_d = (state_d != RUN);
    end

    // Registered core reset so it changes exactly on RUN boundaries.
    always_ff @(posedge clk) begin
        if (rst) cpu_rst_q <= 1'b1;
        else     cpu_rst_q <= cpu_rst_d;
    end

    // in_val assembly, sticky error and run counter next values.
    always_comb begin
        val_d  = val_q;
        vptr_d = vptr_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (hs && wr_sel == SEL_VAL) begin
            unique case (vptr_q)
                2'd0:    begin val_d[15:0]  = wr_word; vptr_d = 2'd1; end
                2'd1:    begin val_d[31:16] = wr_word; vptr_d = 2'd2; end
                default: err_d = 1'b1;
            endcase
        end
        if (hs && wr_sel == SEL_BAD) err_d = 1'b1;
        if (instr_ovf || data_ovf)   err_d = 1'b1;
        if (state_q == RUN && state_d == RUN) cnt_d = cnt_q + 16'd1;
        if (clear) begin
            val_d  = '0;
            vptr_d = '0;
            err_d  = 1'b0;
            cnt_d  = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q  <= '0;
            vptr_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            val_q  <= val_d;
            vptr_q <= vptr_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign in_val    = val_q;
    assign cpu_rst   = cpu_rst_q;
    assign err       = err_q;
    assign run_count = cnt_q;

endmodule

// File: tb/tb_mips16_program_loader.sv
// Directed bench for mips16_program_loader with hand-computed expectations.
// Each check is an immediate assertion that counts and reports failures.
module tb_mips16_program_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [1:0]   wr_sel;
    logic [15:0]  wr_word;
    logic         wr_last;
    logic         clear;
    logic         abort;
    logic [383:0] in_instr;
    logic [383:0] in_data;
    logic [31:0]  in_val;
    logic         cpu_rst;
    logic         done;
    logic         err;
    logic [15:0]  run_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips16_program_loader dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_sel    (wr_sel),
        .wr_word   (wr_word),
        .wr_last   (wr_last),
        .clear     (clear),
        .abort     (abort),
        .in_instr  (in_instr),
        .in_data   (in_data),
        .in_val    (in_val),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err),
        .run_count (run_count)
    );

    task automatic chk(input string tag, input logic [383:0] obs,
                       input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [15:0] w,
                        input logic l);
        wr_valid = 1'b1;
        wr_sel   = s;
        wr_word  = w;
        wr_last  = l;
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 384'(wr_ready), 384'd1);
        chk({tag, "_instr"}, in_instr, '0);
        chk({tag, "_data"}, in_data, '0);
        chk({tag, "_val"}, 384'(in_val), '0);
        chk({tag, "_cpurst"}, 384'(cpu_rst), 384'd1);
        chk({tag, "_done"}, 384'(done), '0);
        chk({tag, "_err"}, 384'(err), '0);
        chk({tag, "_cnt"}, 384'(run_count), '0);
    endtask

    logic [383:0] exp_img;
    int           cyc;

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_sel = 2'b00; wr_word = '0;
        wr_last = 1'b0; clear = 1'b0; abort = 1'b0;
        step(); step();
        rst = 1'b0;
        chk_idle("reset");

        // abort in LOAD is ignored
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_load_ready", 384'(wr_ready), 384'd1);
        chk("abort_load_done", 384'(done), '0);

        // 1: basic load and run
        send(2'b00, 16'h2001, 1'b0);
        chk("t1_lat", in_instr, 384'h2001);
        send(2'b00, 16'h4002, 1'b0);
        chk("t1_cpurst_load", 384'(cpu_rst), 384'd1);
        send(2'b00, 16'hE003, 1'b1);
        chk("t1_instr", in_instr, 384'hE003_4002_2001);
        chk("t1_cpurst_run", 384'(cpu_rst), '0);
        chk("t1_ready_run", 384'(wr_ready), '0);
        chk("t1_cnt0", 384'(run_count), '0);
        cyc = 0;
        while (!done && cyc < 200) begin
            step();
            cyc++;
        end
        chk("t1_run_len", 384'(cyc), 384'd64);
        chk("t1_cnt_done", 384'(run_count), 384'd63);
        chk("t1_cpurst_done", 384'(cpu_rst), 384'd1);
        send(2'b00, 16'hFFFF, 1'b0);
        chk("t1_done_ignore", in_instr, 384'hE003_4002_2001);
        chk("t1_done_hold", 384'(done), 384'd1);
        step();
        chk("t1_cnt_hold", 384'(run_count), 384'd63);

        // 5b: clear in DONE
        pulse_clear();
        chk_idle("clr_done");

        // 2: data overflow and illegal select
        exp_img = '0;
        for (int i = 0; i < 24; i++) begin
            send(2'b01, 16'(i), 1'b0);
            exp_img[i*16 +: 16] = 16'(i);
        end
        chk("t2_err_pre", 384'(err), '0);
        send(2'b01, 16'd24, 1'b0);
        chk("t2_data", in_data, exp_img);
        chk("t2_err_ovf", 384'(err), 384'd1);
        send(2'b11, 16'h7777, 1'b0);
        chk("t2_err_sticky", 384'(err), 384'd1);
        chk("t2_data_keep", in_data, exp_img);
        pulse_clear();
        chk("t2_clr_err", 384'(err), '0);
        send(2'b11, 16'h1234, 1'b0);
        chk("t2_bad_sel", 384'(err), 384'd1);
        chk("t2_bad_instr", in_instr, '0);
        pulse_clear();

        // 3: in_val assembly
        send(2'b10, 16'hBEEF, 1'b0);
        chk("t3_val_lo", 384'(in_val), 384'h0000BEEF);
        send(2'b10, 16'hDEAD, 1'b0);
        chk("t3_val", 384'(in_val), 384'hDEADBEEF);
        chk("t3_err0", 384'(err), '0);
        send(2'b10, 16'h1234, 1'b0);
        chk("t3_val_keep", 384'(in_val), 384'hDEADBEEF);
        chk("t3_err1", 384'(err), 384'd1);

        // 4: abort; a bad-select word with last still starts RUN
        send(2'b11, 16'h0BAD, 1'b1);
        chk("t4_run", 384'(cpu_rst), '0);
        for (int i = 0; i < 10; i++) step();
        chk("t4_cnt10", 384'(run_count), 384'd10);
        abort = 1'b1; step(); abort = 1'b0;
        chk("t4_done", 384'(done), 384'd1);
        chk("t4_cnt", 384'(run_count), 384'd10);
        chk("t4_cpurst", 384'(cpu_rst), 384'd1);
        step(); step();
        chk("t4_cnt_frz", 384'(run_count), 384'd10);
        chk("t4_val", 384'(in_val), 384'hDEADBEEF);
        pulse_clear();

        // 5: clear together with abort in RUN
        send(2'b00, 16'hCAFE, 1'b1);
        step(); step(); step();
        chk("t5_cnt3", 384'(run_count), 384'd3);
        clear = 1'b1; abort = 1'b1; step();
        clear = 1'b0; abort = 1'b0;
        chk_idle("t5");

        // 6: reset during a handshake
        send(2'b00, 16'hAAAA, 1'b0);
        chk("t6_pre", in_instr, 384'hAAAA);
        wr_valid = 1'b1; wr_sel = 2'b00; wr_word = 16'h5555;
        rst = 1'b1; step();
        rst = 1'b0; wr_valid = 1'b0;
        chk_idle("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips16_program_loader.md
Name: mips16_program_loader

Overview:
Upstream stage of the MIPS16 core. Accepts a serial stream of 16-bit words over a valid/ready handshake and assembles the core's flat 384-bit instruction image, 384-bit data image and 32-bit in_val.
Holds the core in reset while loading, releases it for a bounded number of cycles, then parks it back in reset and flags completion.
All images are registered and frozen while the core runs.

Parameters:
WORDS, 24, 16-bit words per image (image width = 16*WORDS = 384)
RUN_CYCLES, 64, core cycles per run; legal range 1..65535 (16-bit counter)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
wr_valid  in  1  word valid
wr_ready  out  1  loader can accept a word
wr_sel  in  2  target: 00 instr, 01 data, 10 in_val, 11 illegal
wr_word  in  16  word payload
wr_last  in  1  final word of the load; qualified by the handshake
clear  in  1  pulse: return to LOAD and zero all images
abort  in  1  pulse: end RUN early
in_instr  out  384  instruction image to the core
in_data  out  384  data image to the core
in_val  out  32  value image to the core
cpu_rst  out  1  registered reset to the core
done  out  1  high in DONE
err  out  1  sticky: illegal wr_sel or image overflow
run_count  out  16  core cycles elapsed in the current or last run

Behaviour:
- States: LOAD, RUN, DONE. On rst: state LOAD, all images 0, all pointers 0, cpu_rst=1, done=0, err=0, run_count=0, wr_ready=1.
- A handshake is wr_valid & wr_ready. wr_ready=1 only in LOAD.
- Instr/data write: word written to bits [16p+15:16p] of the selected image, where p is that image's pointer; p then increments. Each image has its own pointer.
- Overflow: a write when p==WORDS discards the word, leaves p at WORDS and sets err.
- in_val: the first word goes to [15:0], the second to [31:16]. A third or later word is discarded and sets err.
- wr_sel==11: word discarded, err set. The handshake still completes and wr_last still applies.
- Handshake with wr_last=1: word is written, then LOAD→RUN on the next edge. Loading zero words is legal only through this path.
- Register latency: a write is visible on the image outputs the cycle after its handshake.
- cpu_rst is a registered output:
  - It falls on the edge that enters RUN, so the core's first active cycle is the first RUN cycle.
  - It rises on the edge that leaves RUN.
- RUN:
  - run_count is 0 in the first RUN cycle and increments each cycle.
  - When run_count==RUN_CYCLES-1, the next state is DONE. run_count holds its final value in DONE.
  - abort in RUN → DONE on the next edge, and run_count freezes.
  - abort outside RUN is ignored.
- DONE: done=1, cpu_rst=1, images held. wr_valid is ignored.
- clear, from any state:
  - Next state LOAD; images, pointers, err and run_count all zeroed; done=0; cpu_rst=1.
  - Priority: rst > clear > abort > wr_last / run terminal count.
- clear in RUN aborts the run and reasserts cpu_rst on the next edge.
- Image contents never change outside LOAD.

Decomposition:
- Package mips16_loader_pkg holds:
  - state enum: LOAD, RUN, DONE
  - wr_sel codes: SEL_INSTR, SEL_DATA, SEL_VAL, SEL_BAD
  - WORD_W = 16
- One sub-module, loader_image_reg, instantiated twice (instr, data). It holds one word-addressed image with its pointer:
  - inputs: we, clr, word
  - outputs: image, overflow pulse
- The in_val register, FSM and run counter live in the top module.

Test Plan:
1. Basic load-and-run:
   - Stimulus: after rst, send 3 instr words 16'h2001, 16'h4002, 16'hE003 (last=1).
   - Response: in_instr[47:0]=48'hE003_4002_2001, rest 0. cpu_rst falls the edge after the last handshake. done rises after exactly 64 RUN cycles. run_count=63 in DONE.
2. Overflow and illegal select:
   - Stimulus: 25 data words (0..24), then one word with wr_sel=11.
   - Response: in_data holds words 0..23. Word 24 is dropped. err=1 after word 24 and stays 1.
3. in_val assembly:
   - Stimulus: val words 16'hBEEF then 16'hDEAD.
   - Response: in_val=32'hDEADBEEF. A third val word leaves in_val unchanged and sets err.
4. Abort:
   - Stimulus: abort in RUN cycle with run_count=10.
   - Response: next edge is DONE, run_count=10, cpu_rst=1, done=1.
5. Clear priority:
   - Stimulus: clear and abort together in RUN, then clear in DONE.
   - Response: state LOAD, all images 0, err=0, wr_ready=1 the next cycle. wr_valid during DONE has no effect.
6. Mid-load reset:
   - Stimulus: rst asserted one cycle during a wr_valid=1 handshake.
   - Response: that word is not written, all outputs at reset values, state LOAD.
